// File: rtl/sram_scan_driver.sv
// Command serializer for sram_scan_wrapper: chain reset, mode/count/addr header, write data.
// Optional read-capture path (RDWAIT/RDCAP, rd_data/rd_valid) is enabled by SRAM_SCAN_DRV_RDCAP_EN.
module sram_scan_driver #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RST_CYCLES = 10,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_count,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              chain_rst_n,
  output logic              scan_in,
  input  logic              scan_out,
  output logic              busy,
  output logic              cmd_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned CNT_MAX = max2(max2(RST_CYCLES, RD_LAT), max2(ADDR_W, DATA_W));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned WCNT_W  = ADDR_W + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CRST, S_MODE, S_COUNT, S_ADDR, S_DATA, S_RDWAIT, S_RDCAP, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   hdr_q, hdr_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                last_q, last_d;
  logic                scan_in_q, scan_in_d;
  logic                chain_rst_n_q, chain_rst_n_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                wr_ready_q, wr_ready_d;
  logic                cmd_err_q, cmd_err_d;

`ifdef SRAM_SCAN_DRV_RDCAP_EN
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic [WCNT_W-1:0]   wcnt_init;

  // count field is "words minus one"; widened so the all-ones count does not wrap
  assign wcnt_init = WCNT_W'(count_q) + WCNT_W'(1);
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    count_d   = count_q;
    addr_d    = addr_q;
    hdr_d     = hdr_q;
    word_d    = word_q;
    last_d    = last_q;
    cmd_err_d = cmd_err_q;
`ifdef SRAM_SCAN_DRV_RDCAP_EN
    cap_d      = cap_q;
    wcnt_d     = wcnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d   = S_CRST;
          cnt_d     = CNT_W'(RST_CYCLES - 1);
          write_d   = cmd_write;
          count_d   = cmd_count;
          addr_d    = cmd_addr;
          last_d    = 1'b0;
          cmd_err_d = 1'b0;
        end
      end
      S_CRST: begin
        if (cnt_q == '0) state_d = S_MODE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_MODE: begin
        state_d = S_COUNT;
        hdr_d   = count_q;
        cnt_d   = CNT_W'(ADDR_W - 1);
      end
      S_COUNT: begin
        if (cnt_q == '0) begin
          state_d = S_ADDR;
          hdr_d   = addr_q;
          cnt_d   = CNT_W'(ADDR_W - 1);
        end else begin
          hdr_d = {hdr_q[ADDR_W-2:0], 1'b0};
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ADDR: begin
        if (cnt_q != '0) begin
          hdr_d = {hdr_q[ADDR_W-2:0], 1'b0};
          cnt_d = cnt_q - CNT_W'(1);
        end else if (write_q) begin
          if (wr_valid) begin
            state_d = S_DATA;
            word_d  = wr_data;
            last_d  = wr_last;
            cnt_d   = CNT_W'(DATA_W - 1);
          end else begin
            state_d   = S_DONE;
            cmd_err_d = 1'b1;
          end
        end else begin
`ifdef SRAM_SCAN_DRV_RDCAP_EN
          if (RD_LAT == 0) begin
            state_d = S_RDCAP;
            cnt_d   = CNT_W'(DATA_W - 1);
            wcnt_d  = wcnt_init;
          end else begin
            state_d = S_RDWAIT;
            cnt_d   = CNT_W'(RD_LAT - 1);
          end
`else
          state_d = S_DONE;
`endif
        end
      end
      S_DATA: begin
        if (cnt_q != '0) begin
          word_d = {word_q[DATA_W-2:0], 1'b0};
          cnt_d  = cnt_q - CNT_W'(1);
        end else if (last_q) begin
          state_d = S_DONE;
        end else if (wr_valid) begin
          word_d = wr_data;
          last_d = wr_last;
          cnt_d  = CNT_W'(DATA_W - 1);
        end else begin
          state_d   = S_DONE;
          cmd_err_d = 1'b1;
        end
      end
`ifdef SRAM_SCAN_DRV_RDCAP_EN
      S_RDWAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RDCAP;
          cnt_d   = CNT_W'(DATA_W - 1);
          wcnt_d  = wcnt_init;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RDCAP: begin
        cap_d = {cap_q[DATA_W-2:0], scan_out};
        if (cnt_q == '0) begin
          rd_valid_d = 1'b1;
          rd_data_d  = {cap_q[DATA_W-2:0], scan_out};
          cnt_d      = CNT_W'(DATA_W - 1);
          if (wcnt_q == WCNT_W'(1)) state_d = S_DONE;
          else                      wcnt_d  = wcnt_q - WCNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // outputs are registered, so they follow the state being entered
    cmd_ready_d   = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    chain_rst_n_d = (state_d != S_CRST);
    wr_ready_d    = write_q && (cnt_d == '0) &&
                    ((state_d == S_ADDR) || ((state_d == S_DATA) && !last_d));
    case (state_d)
      S_MODE:          scan_in_d = write_d;
      S_COUNT, S_ADDR: scan_in_d = hdr_d[ADDR_W-1];
      S_DATA:          scan_in_d = word_d[DATA_W-1];
      default:         scan_in_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      count_q       <= '0;
      addr_q        <= '0;
      hdr_q         <= '0;
      word_q        <= '0;
      last_q        <= 1'b0;
      scan_in_q     <= 1'b0;
      chain_rst_n_q <= 1'b0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      wr_ready_q    <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      count_q       <= count_d;
      addr_q        <= addr_d;
      hdr_q         <= hdr_d;
      word_q        <= word_d;
      last_q        <= last_d;
      scan_in_q     <= scan_in_d;
      chain_rst_n_q <= chain_rst_n_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      wr_ready_q    <= wr_ready_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

`ifdef SRAM_SCAN_DRV_RDCAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q      <= '0;
      wcnt_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      cap_q      <= cap_d;
      wcnt_q     <= wcnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`else
  logic unused_scan_out;
  assign unused_scan_out = scan_out;
  assign rd_data  = '0;
  assign rd_valid = 1'b0;
`endif

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign chain_rst_n = chain_rst_n_q;
  assign scan_in     = scan_in_q;
  assign wr_ready    = wr_ready_q;
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_sram_scan_driver.sv
// Self-checking bench for sram_scan_driver: directed and random commands against a bit-sequence model.
module tb_sram_scan_driver;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int RC = 10;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_count, cmd_addr;
  logic          wr_valid, wr_ready, wr_last;
  logic [DW-1:0] wr_data;
  logic          chain_rst_n, scan_in, scan_out, busy, cmd_err;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  int total;
  int bad;
  logic [DW-1:0] wq  [8];
  logic [DW-1:0] rdw [2048];

  sram_scan_driver #(
    .ADDR_W(AW), .DATA_W(DW), .RST_CYCLES(RC), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_count(cmd_count), .cmd_addr(cmd_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .chain_rst_n(chain_rst_n), .scan_in(scan_in), .scan_out(scan_out),
    .busy(busy), .cmd_err(cmd_err), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // header bit idx: 0 = mode, 1..AW = count MSB first, AW+1..2AW = addr MSB first
  function automatic logic hdr_bit(input logic wr, input logic [AW-1:0] c,
                                   input logic [AW-1:0] a, input int idx);
    if (idx == 0) return wr;
    if (idx <= AW) return c[AW - idx];
    return a[2*AW - idx];
  endfunction

  task automatic start_cmd(input logic wr, input logic [AW-1:0] c, input logic [AW-1:0] a);
    chk("idle_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_count = c; cmd_addr = a;
    step();
    // command inputs are free to change; cmd_valid held high must be ignored
    cmd_write = 1'($urandom); cmd_count = AW'($urandom); cmd_addr = AW'($urandom);
    for (int i = 0; i < RC; i++) begin
      chk("crst_chain", 32'(chain_rst_n), 32'd0);
      chk("crst_scan", 32'(scan_in), 32'd0);
      chk("crst_busy", 32'(busy), 32'd1);
      chk("crst_ready", 32'(cmd_ready), 32'd0);
      chk("crst_err", 32'(cmd_err), 32'd0);
      step();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic run_write(input logic [AW-1:0] c, input logic [AW-1:0] a,
                           input int n, input int drop, input int abort_at);
    int k, nbits, m, rel;
    logic eb, exp_rdy, hs;
    start_cmd(1'b1, c, a);
    k = 0;
    nbits = 1 + 2*AW + ((drop < 0) ? n : drop) * DW;
    m = (drop < 0) ? n : drop + 1;
    for (int idx = 0; idx < nbits; idx++) begin
      wr_valid = (k < n) && (k != drop);
      wr_data  = wq[k];
      wr_last  = (k == n - 1);
      if (idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_chain", 32'(chain_rst_n), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_scan", 32'(scan_in), 32'd0);
        chk("abort_wrready", 32'(wr_ready), 32'd0);
        chk("abort_rdvalid", 32'(rd_valid), 32'd0);
        wr_valid = 1'b0; wr_last = 1'b0;
        return;
      end
      rel = idx - 2*AW;
      if (idx <= 2*AW) eb = hdr_bit(1'b1, c, a, idx);
      else             eb = wq[(rel - 1) / DW][DW - 1 - ((rel - 1) % DW)];
      exp_rdy = (rel >= 0) && ((rel % DW) == 0) && ((rel / DW) < m);
      chk("wr_scan", 32'(scan_in), 32'(eb));
      chk("wr_ready", 32'(wr_ready), 32'(exp_rdy));
      chk("wr_chain", 32'(chain_rst_n), 32'd1);
      chk("wr_busy", 32'(busy), 32'd1);
      hs = exp_rdy && wr_valid;
      step();
      if (hs) k++;
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    chk("done_scan", 32'(scan_in), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_err", 32'(cmd_err), 32'(drop >= 0));
    chk("done_wrready", 32'(wr_ready), 32'd0);
    step();
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_ready", 32'(cmd_ready), 32'd1);
    chk("post_err", 32'(cmd_err), 32'(drop >= 0));
    chk("post_scan", 32'(scan_in), 32'd0);
    chk("post_chain", 32'(chain_rst_n), 32'd1);
  endtask

  task automatic run_read(input logic [AW-1:0] c, input logic [AW-1:0] a);
    int nb;
    start_cmd(1'b0, c, a);
    for (int idx = 0; idx <= 2*AW; idx++) begin
      scan_out = 1'($urandom);
      chk("rd_hdr_scan", 32'(scan_in), 32'(hdr_bit(1'b0, c, a, idx)));
      chk("rd_hdr_wrready", 32'(wr_ready), 32'd0);
      chk("rd_hdr_valid", 32'(rd_valid), 32'd0);
      step();
    end
`ifdef SRAM_SCAN_DRV_RDCAP_EN
    for (int i = 0; i < RL; i++) begin
      chk("rdwait_scan", 32'(scan_in), 32'd0);
      chk("rdwait_busy", 32'(busy), 32'd1);
      chk("rdwait_valid", 32'(rd_valid), 32'd0);
      step();
    end
    nb = (int'(c) + 1) * DW;
    for (int b = 0; b < nb; b++) begin
      scan_out = rdw[b / DW][DW - 1 - (b % DW)];
      chk("rdcap_scan", 32'(scan_in), 32'd0);
      chk("rdcap_busy", 32'(busy), 32'd1);
      chk("rdcap_valid", 32'(rd_valid), 32'((b > 0) && ((b % DW) == 0)));
      if ((b > 0) && ((b % DW) == 0))
        chk("rdcap_data", 32'(rd_data), 32'(rdw[b / DW - 1]));
      step();
    end
    chk("rdlast_valid", 32'(rd_valid), 32'd1);
    chk("rdlast_data", 32'(rd_data), 32'(rdw[c]));
    chk("rdlast_busy", 32'(busy), 32'd1);
    chk("rdlast_scan", 32'(scan_in), 32'd0);
    step();
    chk("rdpost_busy", 32'(busy), 32'd0);
    chk("rdpost_valid", 32'(rd_valid), 32'd0);
`else
    nb = 0;
    chk("rddone_scan", 32'(scan_in), 32'd0);
    chk("rddone_busy", 32'(busy), 32'd1);
    chk("rddone_valid", 32'(rd_valid), 32'd0);
    step();
    chk("rdpost_busy", 32'(busy), 32'd0);
    chk("rdpost_valid", 32'(rd_valid), 32'd0);
    chk("rdpost_data", 32'(rd_data), 32'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, d;
    total = 0; bad = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_count = '0; cmd_addr = '0;
    wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0; scan_out = 1'b0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_chain", 32'(chain_rst_n), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_scan", 32'(scan_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    chk("rst_wrready", 32'(wr_ready), 32'd0);
    chk("rst_rdvalid", 32'(rd_valid), 32'd0);
    chk("rst_rddata", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_chain_pre", 32'(chain_rst_n), 32'd0);
    step();
    chk("rel_chain", 32'(chain_rst_n), 32'd1);
    chk("rel_ready", 32'(cmd_ready), 32'd1);
    chk("rel_scan", 32'(scan_in), 32'd0);
    repeat (3) begin
      step();
      chk("idle_chain", 32'(chain_rst_n), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // directed 5-word write
    wq[0] = 8'hA5; wq[1] = 8'h3C; wq[2] = 8'hFF; wq[3] = 8'h00; wq[4] = 8'h81;
    run_write(11'h7FF, 11'h000, 5, -1, -1);
    // same write, producer stalls before the third word
    run_write(11'h7FF, 11'h000, 5, 2, -1);
    // underrun right at the last address bit
    run_write(11'h003, 11'h155, 2, 0, -1);

    // directed two-word read
    rdw[0] = 8'h5A; rdw[1] = 8'hC3;
    run_read(11'd1, 11'h005);

    // random mix of writes and short reads
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(1, 0) == 1) begin
        n = int'($urandom_range(5, 1));
        for (int j = 0; j < 8; j++) wq[j] = 8'($urandom);
        d = ($urandom_range(3, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
        run_write(AW'($urandom), AW'($urandom), n, d, -1);
      end else begin
        for (int j = 0; j < 4; j++) rdw[j] = 8'($urandom);
        run_read(AW'($urandom_range(3, 0)), AW'($urandom));
      end
    end

    // maximum count read: 2048 words
    for (int j = 0; j < 2048; j++) rdw[j] = 8'($urandom);
    run_read(11'h7FF, AW'($urandom));

    // reset during the data field, then a clean write
    for (int j = 0; j < 8; j++) wq[j] = 8'($urandom);
    run_write(11'h00A, 11'h0F0, 4, -1, 2*AW + 10);
    #2;
    rst_n = 1'b1;
    step();
    chk("rearm_chain", 32'(chain_rst_n), 32'd1);
    chk("rearm_busy", 32'(busy), 32'd0);
    run_write(11'h00A, 11'h0F0, 4, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
